regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, write-back value width.
REQ-002 SHALL have parameter ADDR_W, default 4, register-file address width.
REQ-003 SHALL have parameter DEPTH, default 2, per-requester queue depth (power of two, >=2).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have ports req0_valid, req1_valid  in  1 each  requester write-back request.
REQ-007 SHALL have ports req0_dest, req1_dest  in  ADDR_W each  destination register.
REQ-008 SHALL have ports req0_value, req1_value  in  DATA_W each  value to write.
REQ-009 SHALL have ports req0_ready, req1_ready  out  1 each  queue can accept.
REQ-010 SHALL have port writeBackEn  out  1  register-file write strobe.
REQ-011 SHALL have port Dest_wb  out  ADDR_W  register-file write address.
REQ-012 SHALL have port Result_wb  out  DATA_W  register-file write data.
REQ-013 SHALL have port idle  out  1  both queues empty and no write in flight.

Function
REQ-014 SHALL accept requester i on a posedge where reqi_valid=1 and reqi_ready=1, pushing {dest,value} into queue i.
REQ-015 SHALL drive reqi_ready=1 iff queue i is not full, purely from registered state (no combinational path from any valid input).
REQ-016 SHALL, each posedge, pop at most one entry total from the queue heads and register it onto writeBackEn/Dest_wb/Result_wb.
REQ-017 SHALL deassert writeBackEn on posedges where both queues are empty; Dest_wb/Result_wb hold previous values.
REQ-018 SHALL give latency of exactly 1 cycle from acceptance into an empty, uncontested queue to writeBackEn=1.
REQ-019 SHALL preserve order within each queue; ordering across requesters follows arbitration only.
REQ-020 SHALL allow push and pop of the same queue in one cycle; a full queue being popped still reports ready=0 that cycle (ready registered).
REQ-021 SHALL implement queue pointers as log2(DEPTH)+1 bits with wrap-around; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-022 SHALL, when both requesters hit the same Dest_wb, issue both writes in arbitration order with no merging.
REQ-023 SHALL drive idle=1 iff both queues are empty and writeBackEn=0.
REQ-024 SHALL hold arbitration state in a 1-bit last_grant register (0/1); updated only on cycles where a grant occurs with both heads non-empty.

Reset
REQ-025 SHALL, on rst=0, asynchronously clear all pointers, last_grant=1, writeBackEn=0, Dest_wb=0, Result_wb=0; reqi_ready=1 on first cycle after release.
REQ-026 SHALL discard all queued entries on reset mid-operation; no write issues after reset release until new acceptance.

Configuration
REQ-027 SHALL, with macro WB_ROUND_ROBIN_EN defined, grant the requester other than last_grant when both heads are non-empty.
REQ-028 SHALL, without WB_ROUND_ROBIN_EN, grant requester 0 whenever its queue is non-empty (fixed priority); last_grant remains at reset value.

Verification
REQ-029 SHALL test single write: req0 dest=5 value=0xA5A5A5A5 one cycle -> next cycle writeBackEn=1, Dest_wb=5, Result_wb=0xA5A5A5A5, then idle=1.
REQ-030 SHALL test contention (WB_ROUND_ROBIN_EN): both valid every cycle, dests 1 and 2 -> writes alternate 1,2,1,2 (first grant to req0); without macro -> all req0 writes precede any req1 write.
REQ-031 SHALL test full: req1_valid held, no pops possible (req0 saturating, fixed priority) -> req1_ready=0 after DEPTH accepts, no entry lost or duplicated.
REQ-032 SHALL test same destination: req0 dest=3 value=7 and req1 dest=3 value=9 same cycle -> two writes to 3 in grant order; final register 3 value matches second write.
REQ-033 SHALL test reset mid-operation: rst=0 with both queues full -> writeBackEn=0 immediately, no writes after release, ready=1.
REQ-034 SHALL test wrap-around: 10 sequential req0 writes dests 0..9 at one per cycle -> 10 writes in order, pointers wrap without error.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back requester/register-file bundle for regfile_wb_arbiter.
// master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_dest;
  logic [DATA_W-1:0] req0_value;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_dest;
  logic [DATA_W-1:0] req1_value;
  logic              req1_ready;
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_wb;
  logic              idle;

  modport master (
    output req0_valid, req0_dest, req0_value,
    output req1_valid, req1_dest, req1_value,
    input  req0_ready, req1_ready,
    input  writeBackEn, Dest_wb, Result_wb, idle
  );

  modport slave (
    input  req0_valid, req0_dest, req0_value,
    input  req1_valid, req1_dest, req1_value,
    output req0_ready, req1_ready,
    output writeBackEn, Dest_wb, Result_wb, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two queued write-back requesters arbitrated onto one register-file port.
// WB_ROUND_ROBIN_EN selects round-robin; default is fixed priority to req0.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0] mem0 [DEPTH];
  logic [EW-1:0] mem1 [DEPTH];
  logic [PW-1:0] wp0, rp0;
  logic [PW-1:0] wp1, rp1;
  logic          empty0, empty1;
  logic          full0, full1;
  logic          push0, push1;
  logic          grant0, grant1;
  logic          last_grant;
  logic          wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [EW-1:0] head;

  always_comb begin
    empty0 = (wp0 == rp0);
    empty1 = (wp1 == rp1);
    full0  = (wp0[AW] != rp0[AW]) &&
             (wp0[AW-1:0] == rp0[AW-1:0]);
    full1  = (wp1[AW] != rp1[AW]) &&
             (wp1[AW-1:0] == rp1[AW-1:0]);
    push0  = bus.req0_valid && !full0;
    push1  = bus.req1_valid && !full1;
    // last_grant stays 1 in fixed mode, so contention always picks req0
    grant0 = !empty0 && (empty1 || last_grant);
    grant1 = !empty1 && (empty0 || !last_grant);
    head   = grant0 ? mem0[rp0[AW-1:0]]
                    : mem1[rp1[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push0)
      mem0[wp0[AW-1:0]] <= {bus.req0_dest, bus.req0_value};
    if (push1)
      mem1[wp1[AW-1:0]] <= {bus.req1_dest, bus.req1_value};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp0        <= '0;
      rp0        <= '0;
      wp1        <= '0;
      rp1        <= '0;
      last_grant <= 1'b1;
      wb_en      <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
    end else begin
      if (push0)  wp0 <= wp0 + PW'(1);
      if (push1)  wp1 <= wp1 + PW'(1);
      if (grant0) rp0 <= rp0 + PW'(1);
      if (grant1) rp1 <= rp1 + PW'(1);
      wb_en <= grant0 | grant1;
      if (grant0 | grant1)
        {wb_dest, wb_data} <= head;
`ifdef WB_ROUND_ROBIN_EN
      if (!empty0 && !empty1)
        last_grant <= grant1;
`endif
    end
  end

  assign bus.req0_ready  = !full0;
  assign bus.req1_ready  = !full1;
  assign bus.writeBackEn = wb_en;
  assign bus.Dest_wb     = wb_dest;
  assign bus.Result_wb   = wb_data;
  assign bus.idle        = empty0 && empty1 && !wb_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes
// expected writes, a negedge monitor pops and compares each write.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AWD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AWD)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AWD), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int n_writes = 0;
  bit sb_off = 1'b0;
  logic [AWD+DW-1:0] exp_q[$];
  logic [DW-1:0] obs_rf [16];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  task automatic expect_wr(input int d, input int v);
    exp_q.push_back({AWD'(d), DW'(v)});
  endtask

  always @(negedge clk) begin
    if (rst && bus.writeBackEn && !sb_off) begin
      n_writes++;
      obs_rf[bus.Dest_wb] = bus.Result_wb;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got dest %0d value 0x%0h expected none",
                 bus.Dest_wb, bus.Result_wb);
      end else begin
        chk("wb_write", 64'({bus.Dest_wb, bus.Result_wb}),
            64'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.idle) && n < 50) begin
      cyc();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    int j;
    int w0;
    bit acc1;
    idle_inputs();
    bus.req0_dest  = '0;
    bus.req0_value = '0;
    bus.req1_dest  = '0;
    bus.req1_value = '0;

    // reset state
    #12;
    chk("rst_wben", 64'(bus.writeBackEn), 64'd0);
    chk("rst_dest", 64'(bus.Dest_wb), 64'd0);
    chk("rst_result", 64'(bus.Result_wb), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    #10 rst = 1'b1;
    cyc();
    chk("rst_ready0", 64'(bus.req0_ready), 64'd1);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd1);

    // single write with latency check
    expect_wr(5, 32'hA5A5A5A5);
    bus.req0_valid = 1'b1;
    bus.req0_dest  = 4'd5;
    bus.req0_value = 32'hA5A5A5A5;
    cyc();
    bus.req0_valid = 1'b0;
    chk("single_no_early", 64'(bus.writeBackEn), 64'd0);
    cyc();
    chk("single_wben", 64'(bus.writeBackEn), 64'd1);
    chk("single_dest", 64'(bus.Dest_wb), 64'd5);
    chk("single_result", 64'(bus.Result_wb), 64'hA5A5A5A5);
    cyc();
    chk("single_wben_off", 64'(bus.writeBackEn), 64'd0);
    chk("single_idle", 64'(bus.idle), 64'd1);
    chk("single_dest_hold", 64'(bus.Dest_wb), 64'd5);

    // contention: both valid two cycles, dests 1 and 2
`ifdef WB_ROUND_ROBIN_EN
    expect_wr(1, 'h100);
    expect_wr(2, 'h200);
    expect_wr(1, 'h101);
    expect_wr(2, 'h201);
`else
    expect_wr(1, 'h100);
    expect_wr(1, 'h101);
    expect_wr(2, 'h200);
    expect_wr(2, 'h201);
`endif
    for (int k = 0; k < 2; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_dest  = 4'd1;
      bus.req0_value = 32'h100 + k;
      bus.req1_valid = 1'b1;
      bus.req1_dest  = 4'd2;
      bus.req1_value = 32'h200 + k;
      cyc();
    end
    idle_inputs();
    drain("contention_drain");

    // same destination, same cycle
`ifdef WB_ROUND_ROBIN_EN
    expect_wr(3, 9);
    expect_wr(3, 7);
`else
    expect_wr(3, 7);
    expect_wr(3, 9);
`endif
    bus.req0_valid = 1'b1;
    bus.req0_dest  = 4'd3;
    bus.req0_value = 32'd7;
    bus.req1_valid = 1'b1;
    bus.req1_dest  = 4'd3;
    bus.req1_value = 32'd9;
    cyc();
    idle_inputs();
    drain("samedest_drain");
`ifdef WB_ROUND_ROBIN_EN
    chk("samedest_final", 64'(obs_rf[3]), 64'd7);
`else
    chk("samedest_final", 64'(obs_rf[3]), 64'd9);
`endif

`ifndef WB_ROUND_ROBIN_EN
    // req1 starved by saturating req0: fills after DEPTH accepts
    for (int k = 0; k < 6; k++) expect_wr(4, 'h300 + k);
    expect_wr(6, 'h400);
    expect_wr(6, 'h401);
    j = 0;
    for (int k = 0; k < 6; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_dest  = 4'd4;
      bus.req0_value = 32'h300 + k;
      bus.req1_valid = 1'b1;
      bus.req1_dest  = 4'd6;
      bus.req1_value = 32'h400 + j;
      acc1 = bus.req1_ready;
      cyc();
      if (acc1) j++;
    end
    chk("full_ready1", 64'(bus.req1_ready), 64'd0);
    chk("full_accepts1", 64'(j), 64'd2);
    idle_inputs();
    drain("full_drain");
`endif

    // reset while queues are loaded
    sb_off = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_dest  = 4'd8;
      bus.req0_value = 32'h600 + k;
      bus.req1_valid = 1'b1;
      bus.req1_dest  = 4'd9;
      bus.req1_value = 32'h700 + k;
      cyc();
    end
    chk("midrst_busy", 64'(bus.idle), 64'd0);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_wben", 64'(bus.writeBackEn), 64'd0);
    chk("midrst_dest", 64'(bus.Dest_wb), 64'd0);
    chk("midrst_result", 64'(bus.Result_wb), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb_off = 1'b0;
    w0 = n_writes;
    cyc();
    chk("midrst_ready0", 64'(bus.req0_ready), 64'd1);
    chk("midrst_ready1", 64'(bus.req1_ready), 64'd1);
    chk("midrst_idle", 64'(bus.idle), 64'd1);
    repeat (4) cyc();
    chk("midrst_no_writes", 64'(n_writes - w0), 64'd0);

    // ten back-to-back writes wrap the pointers several times
    w0 = n_writes;
    for (int k = 0; k < 10; k++) begin
      expect_wr(k, 'h500 + k);
      bus.req0_valid = 1'b1;
      bus.req0_dest  = 4'(k);
      bus.req0_value = 32'h500 + k;
      cyc();
    end
    idle_inputs();
    drain("wrap_drain");
    chk("wrap_count", 64'(n_writes - w0), 64'd10);
    chk("wrap_last", 64'(obs_rf[9]), 64'h509);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
